// File: rtl/a2d_pkg.sv
// Shared constants and types for the A2D SPI responder.
package a2d_pkg;

  // Channels used by the Segway A2D interface
  localparam logic [2:0] CHAN_LFT  = 3'd0;
  localparam logic [2:0] CHAN_RGHT = 3'd4;
  localparam logic [2:0] CHAN_BATT = 3'd5;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_BITS  = 12;
  localparam int unsigned CH_LSB     = 11;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer plus a history flop for rise/fall detection.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic ff1, ff2, ff3;

  // Synchronizer chain; ff3 holds the previous synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1 <= RST_VAL;
      ff2 <= RST_VAL;
      ff3 <= RST_VAL;
    end else begin
      ff1 <= d;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign q    = ff2;
  assign rise = ff2 & ~ff3;
  assign fall = ~ff2 & ff3;

endmodule

// File: rtl/a2d_spi_resp.sv
// A2D converter SPI responder: latches a 16-bit command selecting a channel and
// returns that channel's 12-bit conversion in the following frame.
// Optional: define A2D_XACT_CNT_EN to add xact_cnt/err_cnt statistics outputs.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned RST_CH = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          SS_n,
  input  logic                          SCLK,
  input  logic                          MOSI,
  output logic                          MISO,
  input  logic [DATA_BITS*NUM_CH-1:0]   ch_data,
  output logic [FRAME_BITS-1:0]         cmd,
  output logic                          cmd_vld,
  output logic [2:0]                    chan,
  output logic                          frame_err
`ifdef A2D_XACT_CNT_EN
  ,
  output logic [15:0]                   xact_cnt,
  output logic [7:0]                    err_cnt
`endif
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX  = 5'(FRAME_BITS + 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_pin_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SS_n),
    .q    (ss_lvl),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SCLK),
    .q    (sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (MOSI),
    .q    (mosi_sync),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  state_t                  state_q, state_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d, tx_q, tx_d, cmd_q, cmd_d;
  logic [2:0]              chan_q, chan_d;
  logic                    cmd_vld_q, cmd_vld_d, frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0]    snap;

  // Select the current channel's conversion; out-of-range channels read as zero
  always_comb begin
    snap = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (chan_q == 3'(k)) snap = ch_data[k*DATA_BITS +: DATA_BITS];
    end
  end

  // Next-state logic; within a clk the SCLK edge is applied before frame end
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cmd_d       = cmd_q;
    chan_d      = chan_q;
    cmd_vld_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_d      = {{(FRAME_BITS-DATA_BITS){1'b0}}, snap};
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_d = {rx_q[FRAME_BITS-2:0], mosi_sync};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        // The fall preceding the first rise must not shift: MSB is already on MISO
        if (sclk_fall && (bit_cnt_q != '0)) tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_d == CNT_FULL) begin
            cmd_d       = rx_d;
            cmd_vld_d   = 1'b1;
            chan_d      = rx_d[CH_LSB+2:CH_LSB];
            frame_err_d = 32'(rx_d[CH_LSB+2:CH_LSB]) >= NUM_CH;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_q       <= '0;
      chan_q      <= 3'(RST_CH);
      cmd_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_q       <= cmd_d;
      chan_q      <= chan_d;
      cmd_vld_q   <= cmd_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = tx_q[FRAME_BITS-1];
  assign cmd       = cmd_q;
  assign cmd_vld   = cmd_vld_q;
  assign chan      = chan_q;
  assign frame_err = frame_err_q;

`ifdef A2D_XACT_CNT_EN
  logic [15:0] xact_cnt_q;
  logic [7:0]  err_cnt_q;

  // Transaction counter wraps; error counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xact_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (cmd_vld_d) xact_cnt_q <= xact_cnt_q + 16'd1;
      if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign xact_cnt = xact_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp with a transaction-level model and pulse scoreboard.
module tb_a2d_spi_resp;
  import a2d_pkg::*;

  localparam int unsigned NCH = 6;
  localparam int unsigned RCH = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1;
  logic SCLK = 1'b1;
  logic MOSI = 1'b0;
  logic MISO, cmd_vld, frame_err;
  logic [15:0] cmd;
  logic [2:0] chan;
  logic [11:0] chv [NCH];
  logic [12*NCH-1:0] ch_data;
`ifdef A2D_XACT_CNT_EN
  logic [15:0] xact_cnt;
  logic [7:0] err_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [15:0] cmd;
    logic [2:0]  chan;
  } ev_t;

  ev_t evq[$];
  ev_t cev;
  logic [15:0] m_cmd = 16'h0000;
  logic [2:0] m_chan = 3'(RCH);
  logic [15:0] last_rsp;

  always #10 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < int'(NCH); k++) ch_data[12*k +: 12] = chv[k];
  end

  a2d_spi_resp #(.NUM_CH(NCH), .RST_CH(RCH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .ch_data  (ch_data),
    .cmd      (cmd),
    .cmd_vld  (cmd_vld),
    .chan     (chan),
    .frame_err(frame_err)
`ifdef A2D_XACT_CNT_EN
    ,
    .xact_cnt (xact_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every cmd_vld/frame_err pulse must match the next expected frame outcome
  always @(negedge clk) begin
    if (rst_n && (cmd_vld || frame_err)) begin
      if (evq.size() == 0) begin
        check("unexpected_pulse", 32'({cmd_vld, frame_err}), 32'd0);
      end else begin
        cev = evq.pop_front();
        check("pulse_vld", 32'(cmd_vld), 32'(cev.vld));
        check("pulse_err", 32'(frame_err), 32'(cev.err));
        check("pulse_cmd", 32'(cmd), 32'(cev.cmd));
        check("pulse_chan", 32'(chan), 32'(cev.chan));
      end
    end
  end

  // SPI master frame; called at a negedge. rst_at >= 0 resets the DUT at that bit.
  task automatic xfer(input logic [15:0] word, input int nbits, input int half,
                      input int gap, input int rst_at, input bit chg);
    logic [15:0] exp_rsp, got;
    ev_t e;
    exp_rsp = (m_chan < NCH) ? {4'h0, chv[m_chan]} : 16'h0000;
    got = '0;
    SS_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_chan", 32'(chan), RCH);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_vld", 32'(cmd_vld), 32'd0);
        rst_n = 1'b1;
        m_chan = 3'(RCH);
        m_cmd = 16'h0000;
        repeat (6) @(negedge clk);
        return;
      end
      SCLK = 1'b0;
      MOSI = (i < 16) ? word[15-i] : 1'b0;
      repeat (half) @(negedge clk);
      SCLK = 1'b1;
      got = {got[14:0], MISO};
      if (chg && i == 0 && m_chan < NCH) chv[m_chan] = ~chv[m_chan];
      repeat (half) @(negedge clk);
    end
    SS_n = 1'b1;
    if (nbits == 16) begin
      check("response", 32'(got), 32'(exp_rsp));
      e.vld = 1'b1;
      e.err = (word[13:11] >= NCH);
      e.cmd = word;
      e.chan = word[13:11];
      m_cmd = word;
      m_chan = word[13:11];
    end else begin
      e.vld = 1'b0;
      e.err = 1'b1;
      e.cmd = m_cmd;
      e.chan = m_chan;
    end
    evq.push_back(e);
    last_rsp = got;
    repeat (gap) @(negedge clk);
  endtask

  logic [15:0] rr_cmds [3];

  initial begin
    chv[0] = 12'hABC; chv[1] = 12'h111; chv[2] = 12'h222;
    chv[3] = 12'h333; chv[4] = 12'h123; chv[5] = 12'h5A5;
    rr_cmds[0] = 16'h4123;  // channel 0, ignored bits set
    rr_cmds[1] = 16'hA5A5;  // channel 4
    rr_cmds[2] = 16'h2FFF;  // channel 5
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(MISO), 32'd0);
    check("reset_cmd", 32'(cmd), 32'd0);
    check("reset_vld", 32'(cmd_vld), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_chan", 32'(chan), RCH);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // First frame returns the reset channel; command selects CHAN_RGHT
    xfer(16'h2000, 16, 8, 6, -1, 1'b0);
    check("t1_rsp", 32'(last_rsp), 32'h0ABC);
    check("t1_cmd", 32'(cmd), 32'h2000);
    check("t1_chan", 32'(chan), 32'(CHAN_RGHT));

    // ch_data[4] altered mid-frame must not disturb the snapshot
    xfer(16'h2800, 16, 8, 6, -1, 1'b1);
    check("t2_rsp", 32'(last_rsp), 32'h0123);
    check("t2_chan", 32'(chan), 32'(CHAN_BATT));

    // Round-robin, back-to-back with a 1-clk gap
    for (int r = 0; r < 9; r++) begin
      xfer(rr_cmds[r % 3], 16, 16, 1, -1, 1'b0);
      if (r == 0) check("t3_first_rsp", 32'(last_rsp), 32'h05A5);
    end
    repeat (6) @(negedge clk);
    check("t3_chan", 32'(chan), 32'(CHAN_BATT));

    // Aborted (9 bits) and over-length (17 bits) frames leave cmd/chan unchanged
    xfer(16'h0000, 9, 8, 6, -1, 1'b0);
    check("t4_cmd", 32'(cmd), 32'h2FFF);
    check("t4_chan", 32'(chan), 32'd5);
    xfer(16'h2000, 17, 8, 6, -1, 1'b0);
    check("t4_long_chan", 32'(chan), 32'd5);
    xfer(16'h0000, 16, 8, 6, -1, 1'b0);
    check("t4_next_rsp", 32'(last_rsp), 32'h05A5);

    // Out-of-range channel 7: error, pointer still loaded, next response zero
    xfer(16'h3800, 16, 8, 6, -1, 1'b0);
    check("t5_chan", 32'(chan), 32'd7);
    xfer(16'h0000, 16, 8, 6, -1, 1'b0);
    check("t5_rsp", 32'(last_rsp), 32'h0000);

    // Reset after 7 bits abandons the frame
    xfer(16'hFFFF, 16, 8, 6, 7, 1'b0);
`ifdef A2D_XACT_CNT_EN
    check("t6_xact0", 32'(xact_cnt), 32'd0);
    check("t6_err0", 32'(err_cnt), 32'd0);
`endif
    xfer(16'h2000, 16, 8, 6, -1, 1'b0);
    check("t6_rsp", 32'(last_rsp), 32'h0ABC);
    xfer(16'h2800, 16, 8, 6, -1, 1'b0);
    xfer(16'h0000, 16, 8, 6, -1, 1'b0);
`ifdef A2D_XACT_CNT_EN
    check("t6_xact3", 32'(xact_cnt), 32'd3);
`endif
    check("t6_chan", 32'(chan), 32'(CHAN_LFT));
    check("events_drained", 32'(evq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- SPI responder: the A2D converter end of the link the Segway's A2D interface drives through its 16-bit SPI master.
- Receives the 16-bit command word whose bits [13:11] select a channel, and returns that channel's 12-bit conversion during the next transaction.
- Synthesizable; used as the A2D model in the full-chip bench and on the FPGA bring-up board, where it is fed by the load-cell and battery stimulus registers.

Parameters:
- NUM_CH, 8, number of valid channels (1..8); channel indices >= NUM_CH are out of range.
- RST_CH, 0, channel pointer value after reset.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  active-low slave select from master
- SCLK  input  1  serial clock from master, idles high, frequency at most clk/8
- MOSI  input  1  command bit from master
- MISO  output  1  response bit to master
- ch_data  input  12*NUM_CH  conversion values; channel k occupies [12k+11:12k]
- cmd  output  16  last complete command word received
- cmd_vld  output  1  one-clk pulse when a 16-bit frame completes
- chan  output  3  channel pointer that the next response will use
- frame_err  output  1  one-clk pulse on an aborted or over-length frame, or an out-of-range channel

Behaviour:
- Reset state:
  - MISO=0, cmd=16'h0000, cmd_vld=0, frame_err=0, chan=RST_CH.
  - State is IDLE, bit_cnt=0, shift registers are 0.
  - Reset mid-frame abandons the frame; nothing latches.
- Input synchronization:
  - SS_n, SCLK and MOSI each pass through 2 sync flops plus 1 history flop.
  - Edge detects (SS_n fall/rise, SCLK rise/fall) are 3 clk behind the pins.
  - SS_n and SCLK sync flops reset to 1.
- State machine, IDLE -> SHIFT -> IDLE:
  - IDLE: MISO = tx_shft[15]. On SS_n fall:
    - tx_shft <= {4'h0, ch_data[chan]}, or 16'h0000 if chan >= NUM_CH.
    - bit_cnt <= 0; go to SHIFT.
    - The ch_data snapshot is taken here only, so later changes do not affect the frame.
  - SHIFT, on SCLK rise: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit_cnt increments, saturating at 17.
  - SHIFT, on SCLK fall: tx_shft shifts left with 0 fill only if bit_cnt != 0. The fall before the first rise is ignored, so the MSB is valid before the first sampling edge.
  - SHIFT, on SS_n rise with bit_cnt == 16:
    - cmd <= rx_shft.
    - cmd_vld pulses for 1 clk.
    - chan <= rx_shft[13:11].
    - frame_err pulses if rx_shft[13:11] >= NUM_CH; chan is still loaded.
    - Return to IDLE.
  - SHIFT, on SS_n rise with bit_cnt != 16: frame_err pulses for 1 clk; cmd and chan are unchanged; return to IDLE.
- Response timing: the response to command N appears in frame N+1. The first frame after reset returns ch_data[RST_CH].
- Ignored cmd bits: [15:14] and [10:0] are stored in cmd but otherwise unused.
- Simultaneous SS_n rise and SCLK edge in the same clk: the SCLK edge is processed first, then frame end.
- Gap between frames: SS_n fall in the same clk that IDLE is entered is honoured. A back-to-back frame with a 1-clk gap works.

Optional Feature:
- Macro: A2D_XACT_CNT_EN.
- Defined:
  - Adds output xact_cnt [15:0], reset 0.
  - Increments on each cmd_vld, wrapping 16'hFFFF -> 0.
  - Adds output err_cnt [7:0], incrementing on frame_err and saturating at 8'hFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package a2d_pkg holds:
  - Channel constants CHAN_LFT=3'd0, CHAN_RGHT=3'd4, CHAN_BATT=3'd5.
  - Localparams FRAME_BITS=16, DATA_BITS=12, CH_LSB=11.
  - The state enum typedef {IDLE, SHIFT}.
- One sub-module, spi_pin_sync: a 3-flop synchronizer with rise/fall pulse outputs and a selectable reset value, instantiated for SS_n and SCLK. MOSI uses its data output only.

Test Plan:
1. Reset, ch_data[0]=12'hABC, one 16-bit frame with cmd 16'h2000 -> MISO returns 16'h0ABC; cmd_vld pulses; cmd=16'h2000; chan=4.
2. ch_data[4]=12'h123, next frame cmd 16'h2800 -> MISO returns 16'h0123; chan becomes 5; the next frame returns ch_data[5].
3. Round-robin 0,4,5 repeated 9 frames at SCLK=clk/32 with a 1-clk inter-frame gap -> each response matches the previous cmd's channel; no frame_err.
4. SS_n raised after 9 SCLK rises -> frame_err pulses once; cmd and chan unchanged; the next full frame behaves normally.
5. NUM_CH=6, cmd 16'h3800 (channel 7) -> frame_err pulses; chan=7; the next frame returns 16'h0000.
6. rst_n asserted mid-frame after 7 bits -> MISO=0, chan=RST_CH, no cmd_vld. With A2D_XACT_CNT_EN, xact_cnt=0; after 3 good frames, xact_cnt=3.
